// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier, N-bit operands, 2N-bit product, optional signed mode.
// One operation every N+2 cycles with a start/busy/done handshake and held result.
module seq_multiplier_param #(
  parameter int unsigned N = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic [N-1:0]  mcand_q,  mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q,    acc_d;
  logic [CW-1:0] count_q,  count_d;
  logic          neg_q,    neg_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [W-1:0]  result_q, result_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      // The exit edge of DONE is also a start sample slot, giving N+2 throughput.
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = (signed_mode & x[N-1]) ? N'(~x + N'(1)) : x;
          mplier_d = (signed_mode & y[N-1]) ? N'(~y + N'(1)) : y;
          neg_d    = signed_mode & (x[N-1] ^ y[N-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + (W'(mcand_q) << count_q);
        end
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = neg_q ? (~acc_q + W'(1)) : acc_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param at N=8 and N=16.
module tb_seq_multiplier_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st8, sm8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] res8;
  logic        st16, sm16, busy16, done16;
  logic [15:0] x16, y16;
  logic [31:0] res16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q8[$];
  int          exp_t8[$];
  logic [31:0] exp_q16[$];
  int          exp_t16[$];

  seq_multiplier_param #(.N(8)) dut8 (
    .CLK(clk), .RESET(rst), .start(st8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .result(res8)
  );

  seq_multiplier_param #(.N(16)) dut16 (
    .CLK(clk), .RESET(rst), .start(st16), .signed_mode(sm16),
    .x(x16), .y(y16), .busy(busy16), .done(done16), .result(res16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mul8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    if (sm) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
    end
    return 16'({8'd0, a} * {8'd0, b});
  endfunction

  function automatic logic [31:0] mul16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    if (sm) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return 32'(sa * sb);
    end
    return 32'({16'd0, a} * {16'd0, b});
  endfunction

  // Each done must match the oldest pending expectation in value and cycle.
  always @(negedge clk) begin
    if (done8) begin
      if (exp_q8.size() == 0) check("done8_pending", 64'(exp_q8.size()), 1);
      else begin
        check("res8", 64'(res8), 64'(exp_q8.pop_front()));
        check("lat8", 64'(cyc), 64'(exp_t8.pop_front()));
      end
    end
    if (done16) begin
      if (exp_q16.size() == 0) check("done16_pending", 64'(exp_q16.size()), 1);
      else begin
        check("res16", 64'(res16), 64'(exp_q16.pop_front()));
        check("lat16", 64'(cyc), 64'(exp_t16.pop_front()));
      end
    end
  end

  task automatic start8(input logic sm, input logic [7:0] a, input logic [7:0] b, input bit expect_done);
    @(negedge clk);
    st8 = 1'b1; sm8 = sm; x8 = a; y8 = b;
    if (expect_done) begin
      exp_q8.push_back(mul8(sm, a, b));
      exp_t8.push_back(cyc + 1 + 9);
    end
    @(negedge clk);
    st8 = 1'b0; sm8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
    check("busy8_after_start", 64'(busy8), 1);
  endtask

  task automatic start16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    st16 = 1'b1; sm16 = sm; x16 = a; y16 = b;
    exp_q16.push_back(mul16(sm, a, b));
    exp_t16.push_back(cyc + 1 + 17);
    @(negedge clk);
    st16 = 1'b0; x16 = 16'($urandom); y16 = 16'($urandom);
    check("busy16_after_start", 64'(busy16), 1);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((busy8 || exp_q8.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain8", 64'(exp_q8.size()), 0);
    check("idle8", 64'(busy8), 0);
  endtask

  task automatic wait_idle16();
    int n = 0;
    while ((busy16 || exp_q16.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("drain16", 64'(exp_q16.size()), 0);
    check("idle16", 64'(busy16), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    st8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
    st16 = 1'b0; sm16 = 1'b0; x16 = '0; y16 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy8", 64'(busy8), 0);
    check("rst_done8", 64'(done8), 0);
    check("rst_res8", 64'(res8), 0);
    check("rst_res16", 64'(res16), 0);
    rst = 1'b0;

    // Basic unsigned, then value held after done
    start8(1'b0, 8'd25, 8'd14, 1'b1);
    wait_idle8();
    repeat (3) @(negedge clk);
    check("hold8", 64'(res8), 64'h015E);

    start8(1'b0, 8'hFF, 8'hFF, 1'b1); wait_idle8();
    start8(1'b1, 8'hFF, 8'hFF, 1'b1); wait_idle8();
    start8(1'b1, 8'hFD, 8'h05, 1'b1); wait_idle8();
    start8(1'b1, 8'h80, 8'h80, 1'b1); wait_idle8();
    start8(1'b1, 8'h80, 8'h7F, 1'b1); wait_idle8();
    start8(1'b0, 8'h00, 8'hC3, 1'b1); wait_idle8();
    start8(1'b1, 8'h00, 8'h85, 1'b1); wait_idle8();
    check("signed_extreme8", 64'(res8), 0);

    // Start while busy is ignored
    start8(1'b0, 8'd25, 8'd14, 1'b1);
    repeat (2) @(negedge clk);
    st8 = 1'b1; sm8 = 1'b0; x8 = 8'd2; y8 = 8'd2;
    @(negedge clk);
    st8 = 1'b0;
    wait_idle8();
    check("ignored8", 64'(res8), 64'd350);

    // Start held high: back-to-back operations, done every N+2 cycles
    @(negedge clk);
    st8 = 1'b1; sm8 = 1'b0; x8 = 8'd3; y8 = 8'd4;
    for (int k = 0; k < 3; k++) begin
      exp_q8.push_back(mul8(1'b0, 8'd3, 8'd4));
      exp_t8.push_back(cyc + 1 + 10 * k + 9);
    end
    repeat (21) @(negedge clk);
    st8 = 1'b0;
    wait_idle8();

    // Reset mid-operation: outputs clear asynchronously, no done
    start8(1'b0, 8'd25, 8'd14, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_busy8", 64'(busy8), 0);
    check("async_done8", 64'(done8), 0);
    check("async_res8", 64'(res8), 0);
    @(negedge clk);
    rst = 1'b0;
    start8(1'b0, 8'd7, 8'd6, 1'b1);
    wait_idle8();

    // Wide instance
    start16(1'b0, 16'd40000, 16'd3); wait_idle16();
    start16(1'b1, 16'h8000, 16'h8000); wait_idle16();
    start16(1'b1, 16'hFFFE, 16'd3); wait_idle16();
    check("hold16", 64'(res16), 64'hFFFF_FFFA);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
